arbitrated_selector: RTL
========================

# arbitrated_selector

- Registered N-to-1 selector for the execution stage.
- Accepts operands from `NUMBER_PORTS` independent producer channels, each with a valid/ready handshake.
- Arbitrates among the channels that are valid and forwards one 64-bit word per cycle into a single output register.
- The output register has its own valid/ready handshake. It also reports which port the held word came from.
- Sits between operand producers (forwarding paths, register-file read, immediate generation) and the functional unit that consumes one operand per cycle.

## Interface

Parameters:
- `NUMBER_PORTS`, default 2: number of input channels; must be ≥ 2.
- `PORT_WIDTH`, default 64: data width of every channel.

Ports:
- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset; asynchronous assert, active-low.
- `input_port`, input, `PORT_WIDTH` × `NUMBER_PORTS` (unpacked array): channel data.
- `input_valid`, input, `NUMBER_PORTS`: per-channel valid.
- `input_ready`, output, `NUMBER_PORTS`: per-channel ready; one-hot or zero.
- `output_port`, output, `PORT_WIDTH`: registered selected data.
- `output_source`, output, `$clog2(NUMBER_PORTS)`: index of the channel that supplied `output_port`.
- `output_valid`, output, 1: output register holds a word.
- `output_ready`, input, 1: consumer accepts the word.

## Operation

- **Transfers.**
  - An input transfer on channel i occurs when `input_valid[i] && input_ready[i]`.
  - An output transfer occurs when `output_valid && output_ready`.
- **Acceptance.** `can_accept = !output_valid || output_ready`; the register is empty, or is being drained this cycle.
- **Grant.**
  - Combinational grant vector over `input_valid`, gated by `can_accept`.
  - `input_ready = grant` when `can_accept`, else all zeros.
  - At most one `input_ready` bit is high.
  - No valid inputs → all `input_ready` low.
- **Arbitration.**
  - Fixed priority by default: lowest index wins.
  - Round-robin when compiled in; see Configuration.
- **On an input transfer from channel i:**
  - `output_port <= input_port[i]`
  - `output_source <= i`
  - `output_valid <= 1`
- **Output transfer without an input transfer:** `output_valid <= 0`. `output_port` and `output_source` keep their last values.
- **Simultaneous input and output transfer:** the register is overwritten with the new word and `output_valid` stays 1. This gives full throughput.
- **Stall:** while `output_valid && !output_ready`, `output_port`, `output_source` and `output_valid` are held stable.
- **Dropped requests:** a channel that deasserts `input_valid` without a transfer is simply not considered. No state is kept per request.
- **Protocol requirement:** producers must not make `input_valid` depend on `input_ready`. `input_ready` depends combinationally on `input_valid`.

## Timing

- Latency: 1 cycle from input transfer to `output_valid`/`output_port`.
- Throughput: one word per cycle while `output_ready` stays high.
- Reset values, applied asynchronously on `reset_n` low:
  - `output_valid = 0`
  - `output_port = '0`
  - `output_source = 0`
  - round-robin pointer = `NUMBER_PORTS-1`, so port 0 has first priority after reset.
- `input_ready` is all zeros during reset.
- Reset mid-operation: the held word is discarded. No transfer is considered complete in a cycle during which `reset_n` is low.
- Deassertion of `reset_n` is synchronised externally. The first transfer is possible on the first rising edge with `reset_n` high.

## Configuration

- Macro: `ARBITRATED_SELECTOR_ROUND_ROBIN_EN`.
- **Defined:**
  - A `$clog2(NUMBER_PORTS)`-bit `last_grant` pointer is kept.
  - Search starts at `(last_grant+1) mod NUMBER_PORTS` and wraps, so `NUMBER_PORTS-1` wraps to 0.
  - The first valid channel found is granted.
  - `last_grant <= i` only on an input transfer from channel i. A stalled grant does not advance the pointer.
- **Undefined:**
  - Fixed priority, lowest index wins.
  - No pointer register exists.
  - Starvation of high indices is permitted.

## Test plan

- **Reset and idle.** Assert `reset_n`=0 mid-stream with `output_valid`=1 → `output_valid`=0, `output_port`=0, `output_source`=0 immediately. All `input_ready`=0 while in reset.
- **Single channel, full throughput.**
  - Setup: `NUMBER_PORTS`=4; port 2 valid with data 0x10, 0x11, 0x12 on consecutive cycles; `output_ready`=1.
  - Response: outputs 0x10, 0x11, 0x12 on the following three cycles, `output_source`=2, with no bubbles.
- **Backpressure.**
  - Setup: output holds 0xAA; `output_ready`=0 for 3 cycles; port 0 valid with 0xBB.
  - Response: `input_ready`=0 and output stays 0xAA. When `output_ready`=1, 0xAA transfers and 0xBB is accepted the same cycle, appearing the next cycle.
- **Fixed priority (macro undefined).** Ports 1 and 3 continuously valid, `output_ready`=1 → `output_source`=1 every cycle; port 3 is never granted.
- **Round-robin (macro defined).** All 4 ports continuously valid after reset → `output_source` sequence 0, 1, 2, 3, 0, 1.
- **Round-robin stall and wrap (macro defined).**
  - Setup: last grant 3; ports 0 and 3 valid; `output_ready`=0 for 2 cycles.
  - Response: the pointer does not move while stalled; port 0 is granted first; port 3 is granted on the next transfer.

Source files
------------

// File: rtl/arbitrated_selector.sv
// -----------------------------------------------------------------------------
// arbitrated_selector
//
// Registered N-to-1 operand selector for the execution stage. Several producer
// channels (forwarding paths, register-file read, immediate generation) each
// present one word with a valid/ready handshake. One of the valid channels is
// granted per cycle, and its word is captured into a single output register.
// The output register has its own valid/ready handshake towards the consuming
// functional unit. A word can be accepted in the same cycle that the held word
// drains, so the block sustains one word per cycle.
//
// Arbitration:
//   default                              fixed priority, lowest index wins
//   ARBITRATED_SELECTOR_ROUND_ROBIN_EN   round-robin. The search starts one past
//                                        the last granted port. The pointer
//                                        advances only on a real input transfer.
//
// Ports:
//   clock          sole clock, rising edge
//   reset_n        asynchronous assert, active-low reset
//   input_port     [NUMBER_PORTS] x PORT_WIDTH channel data
//   input_valid    per-channel valid
//   input_ready    per-channel ready (one-hot or zero); combinational from
//                  input_valid, so producers must not gate valid on ready
//   output_port    registered selected word
//   output_source  index of the channel that supplied output_port
//   output_valid   output register holds a word
//   output_ready   consumer takes the held word this cycle
// -----------------------------------------------------------------------------
module arbitrated_selector #(
  parameter int NUMBER_PORTS = 2,
  parameter int PORT_WIDTH   = 64,
  localparam int SRC_W       = $clog2(NUMBER_PORTS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [PORT_WIDTH-1:0] input_port [NUMBER_PORTS],
  input  logic [NUMBER_PORTS-1:0] input_valid,
  output logic [NUMBER_PORTS-1:0] input_ready,
  output logic [PORT_WIDTH-1:0] output_port,
  output logic [SRC_W-1:0]      output_source,
  output logic                  output_valid,
  input  logic                  output_ready
);

  // ---------------------------------------------------------------------------
  // Stage p0: combinational arbitration over the valid channels
  // ---------------------------------------------------------------------------
  logic [NUMBER_PORTS-1:0] grant_p0;
  logic [SRC_W-1:0]        grant_idx_p0;
  logic                    any_vld_p0;
  logic                    can_accept_p0;
  logic                    in_xfer_p0;
  logic [SRC_W-1:0]        scan_idx_p0;

`ifdef ARBITRATED_SELECTOR_ROUND_ROBIN_EN
  logic [SRC_W-1:0] last_grant;

  always_comb begin
    grant_p0     = '0;
    grant_idx_p0 = '0;
    any_vld_p0   = 1'b0;
    scan_idx_p0  = '0;
    // Walk the ports starting one past the last grant, wrapping at
    // NUMBER_PORTS (not at 2**SRC_W, which matters for non-power-of-2 sizes).
    for (int k = 0; k < NUMBER_PORTS; k++) begin
      scan_idx_p0 = SRC_W'((int'(last_grant) + 1 + k) % NUMBER_PORTS);
      if (!any_vld_p0 && input_valid[scan_idx_p0]) begin
        any_vld_p0             = 1'b1;
        grant_p0[scan_idx_p0]  = 1'b1;
        grant_idx_p0           = scan_idx_p0;
      end
    end
  end
`else
  always_comb begin
    grant_p0     = '0;
    grant_idx_p0 = '0;
    any_vld_p0   = 1'b0;
    scan_idx_p0  = '0;
    for (int k = 0; k < NUMBER_PORTS; k++) begin
      scan_idx_p0 = SRC_W'(k);
      if (!any_vld_p0 && input_valid[k]) begin
        any_vld_p0   = 1'b1;
        grant_p0[k]  = 1'b1;
        grant_idx_p0 = scan_idx_p0;
      end
    end
  end
`endif

  // The register may take a new word when it is empty or is draining now.
  assign can_accept_p0 = !output_valid || output_ready;

  // reset_n gates ready so that no producer sees a transfer while the block
  // is held in reset, even though output_valid (and hence can_accept) is idle.
  assign input_ready = (can_accept_p0 && reset_n) ? grant_p0 : '0;
  assign in_xfer_p0  = can_accept_p0 && any_vld_p0;

  // ---------------------------------------------------------------------------
  // Stage p1: output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      output_valid  <= 1'b0;
      output_port   <= '0;
      output_source <= '0;
    end else if (in_xfer_p0) begin
      output_valid  <= 1'b1;
      output_port   <= input_port[grant_idx_p0];
      output_source <= grant_idx_p0;
    end else if (output_ready) begin
      // Drain with nothing to replace it. Data and source keep their values.
      output_valid  <= 1'b0;
    end
  end

`ifdef ARBITRATED_SELECTOR_ROUND_ROBIN_EN
  // The reset value NUMBER_PORTS-1 makes port 0 first in line after reset.
  // A grant that is stalled by backpressure leaves the pointer alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= SRC_W'(NUMBER_PORTS - 1);
    end else if (in_xfer_p0) begin
      last_grant <= grant_idx_p0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Handshake invariants
  // ---------------------------------------------------------------------------
  a_ready_onehot0 : assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(input_ready));

  a_stall_stable : assert property (
    @(posedge clock) disable iff (!reset_n)
    (output_valid && !output_ready) |=>
      (output_valid && $stable(output_port) && $stable(output_source)));

  a_no_ready_when_full : assert property (
    @(posedge clock) disable iff (!reset_n)
    (output_valid && !output_ready) |-> (input_ready == '0));

endmodule
